frost32_mem_bridge: RTL and testbench

Bridges the Frost32 CPU's memory-access port to a word-addressed, byte-enabled memory bus with a req/ack handshake. Accepts one CPU request (read/write, 32/16/8-bit) at a time, generates lane-aligned write data and byte enables, returns lane-shifted zero-extended read data, and drives the CPU's `wait_for_mem` stall input. Illegal sizes, misaligned accesses and bus timeouts are reported as a one-cycle bus error; no memory cycle is issued for illegal sizes or misaligned accesses.

---
 rtl/frost32_mem_bridge.sv | 266 ++++++++++++++++++++++++++
 tb/tb_frost32_mem_bridge.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/frost32_mem_bridge.sv
// ----------------------------------------------------------------------------
// frost32_mem_bridge
//
// Purpose:
//   Converts the Frost32 CPU memory-access port into a word-addressed,
//   byte-enabled memory bus with a req/ack handshake. One CPU access is in
//   flight at a time.
//   - Writes are lane-replicated with matching byte enables.
//   - Reads are lane-shifted and zero-extended.
//   - Illegal sizes and misaligned accesses return a one-cycle bus error
//     without touching memory.
//   - A bus that never acknowledges is abandoned after TIMEOUT_CYCLES.
//
// Parameters:
//   TIMEOUT_CYCLES        max ISSUE cycles without ack (0 = never time out)
//
// Ports:
//   i_clk                 clock, rising edge
//   i_rst_n               asynchronous active-low reset
//   i_cpu_req_mem_access  CPU requests an access
//   i_cpu_access_type     0 = read, 1 = write
//   i_cpu_access_size     0 = 32-bit, 1 = 16-bit, 2 = 8-bit, 3 = illegal
//   i_cpu_addr            byte address
//   i_cpu_data_out        right-justified write data from the CPU
//   o_cpu_data_in         zero-extended read data to the CPU
//   o_cpu_wait_for_mem    CPU stall
//   o_cpu_bus_error       one-cycle error pulse
//   o_mem_req             memory request, held until ack
//   o_mem_we              memory write enable
//   o_mem_addr            word address (cpu_addr[31:2])
//   o_mem_byte_en         byte-lane enables
//   o_mem_wdata           lane-replicated write data
//   i_mem_rdata           memory read data, valid with ack
//   i_mem_ack             memory acknowledge
// ----------------------------------------------------------------------------
module frost32_mem_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cpu_req_mem_access,
  input  logic        i_cpu_access_type,
  input  logic [1:0]  i_cpu_access_size,
  input  logic [31:0] i_cpu_addr,
  input  logic [31:0] i_cpu_data_out,
  output logic [31:0] o_cpu_data_in,
  output logic        o_cpu_wait_for_mem,
  output logic        o_cpu_bus_error,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [29:0] o_mem_addr,
  output logic [3:0]  o_mem_byte_en,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_ack
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  localparam logic [1:0] SZ_WORD = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_BYTE = 2'd2;

  // One extra bit so that TIMEOUT_CYCLES = 255 is reachable as cnt + 1.
  localparam logic [8:0] LP_TIMEOUT = 9'(TIMEOUT_CYCLES);

  state_t      r_state;
  state_t      w_state_next;

  logic        r_mem_we;
  logic [29:0] r_mem_addr;
  logic [3:0]  r_mem_byte_en;
  logic [31:0] r_mem_wdata;
  logic [1:0]  r_size;
  logic [1:0]  r_lane;
  logic        r_err;
  logic [7:0]  r_cnt;
  logic [31:0] r_cpu_data_in;

  logic        w_illegal;
  logic [3:0]  w_byte_en;
  logic [31:0] w_wdata;
  logic [7:0]  w_rbyte;
  logic [31:0] w_rdata_aligned;
  logic        w_timeout;
  logic        w_latch;
  logic        w_capture;
  logic        w_abort;

  // --------------------------------------------------------------------------
  // Request decode (from live CPU inputs, used only in the latch cycle)
  // --------------------------------------------------------------------------
  always_comb begin
    w_illegal = 1'b0;
    unique case (i_cpu_access_size)
      SZ_WORD: w_illegal = (i_cpu_addr[1:0] != 2'b00);
      SZ_HALF: w_illegal = i_cpu_addr[0];
      SZ_BYTE: w_illegal = 1'b0;
      default: w_illegal = 1'b1;
    endcase
  end

  always_comb begin
    w_byte_en = 4'b0000;
    w_wdata   = 32'h0;
    unique case (i_cpu_access_size)
      SZ_WORD: begin
        w_byte_en = 4'b1111;
        w_wdata   = i_cpu_data_out;
      end
      SZ_HALF: begin
        w_byte_en = i_cpu_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata   = {2{i_cpu_data_out[15:0]}};
      end
      SZ_BYTE: begin
        w_byte_en = 4'b0001 << i_cpu_addr[1:0];
        w_wdata   = {4{i_cpu_data_out[7:0]}};
      end
      default: begin
        w_byte_en = 4'b0000;
        w_wdata   = 32'h0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Read alignment (from latched size/lane and the live bus data)
  // --------------------------------------------------------------------------
  always_comb begin
    w_rbyte = 8'h00;
    unique case (r_lane)
      2'd0: w_rbyte = i_mem_rdata[7:0];
      2'd1: w_rbyte = i_mem_rdata[15:8];
      2'd2: w_rbyte = i_mem_rdata[23:16];
      default: w_rbyte = i_mem_rdata[31:24];
    endcase
  end

  always_comb begin
    w_rdata_aligned = 32'h0;
    unique case (r_size)
      SZ_WORD: w_rdata_aligned = i_mem_rdata;
      SZ_HALF: w_rdata_aligned = r_lane[1] ? {16'h0, i_mem_rdata[31:16]}
                                           : {16'h0, i_mem_rdata[15:0]};
      SZ_BYTE: w_rdata_aligned = {24'h0, w_rbyte};
      default: w_rdata_aligned = 32'h0;
    endcase
  end

  // The count seen in a cycle is the number of earlier ack-less ISSUE cycles,
  // so this cycle is the last allowed one when cnt + 1 hits the limit.
  assign w_timeout = (LP_TIMEOUT != 9'd0) && !i_mem_ack &&
                     (({1'b0, r_cnt} + 9'd1) == LP_TIMEOUT);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and handshake outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next       = r_state;
    w_latch            = 1'b0;
    w_capture          = 1'b0;
    w_abort            = 1'b0;
    o_mem_req          = 1'b0;
    o_cpu_wait_for_mem = 1'b0;
    o_cpu_bus_error    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        // Stall combinationally so the CPU holds in the request cycle.
        o_cpu_wait_for_mem = i_cpu_req_mem_access;
        if (i_cpu_req_mem_access) begin
          w_latch      = 1'b1;
          w_state_next = w_illegal ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        o_mem_req          = 1'b1;
        o_cpu_wait_for_mem = 1'b1;
        if (i_mem_ack) begin
          w_capture    = 1'b1;
          w_state_next = ST_RESP;
        end else if (w_timeout) begin
          w_abort      = 1'b1;
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        o_cpu_bus_error = r_err;
        w_state_next    = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem_we      <= 1'b0;
      r_mem_addr    <= 30'h0;
      r_mem_byte_en <= 4'h0;
      r_mem_wdata   <= 32'h0;
      r_size        <= 2'd0;
      r_lane        <= 2'd0;
      r_err         <= 1'b0;
    end else if (w_latch) begin
      r_mem_we      <= i_cpu_access_type;
      r_mem_addr    <= i_cpu_addr[31:2];
      r_mem_byte_en <= w_byte_en;
      r_mem_wdata   <= w_wdata;
      r_size        <= i_cpu_access_size;
      r_lane        <= i_cpu_addr[1:0];
      r_err         <= w_illegal;
    end else if (w_abort) begin
      r_err         <= 1'b1;
    end
  end

  // Read data holds until the next read completion or timeout.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cpu_data_in <= 32'h0;
    end else if (w_abort) begin
      r_cpu_data_in <= 32'h0;
    end else if (w_capture && !r_mem_we) begin
      r_cpu_data_in <= w_rdata_aligned;
    end
  end

  // Cleared while idle so every ISSUE phase starts counting from zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= 8'd0;
    end else if (r_state == ST_ISSUE) begin
      if (!i_mem_ack) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end else begin
      r_cnt <= 8'd0;
    end
  end

  assign o_mem_we      = r_mem_we;
  assign o_mem_addr    = r_mem_addr;
  assign o_mem_byte_en = r_mem_byte_en;
  assign o_mem_wdata   = r_mem_wdata;
  assign o_cpu_data_in = r_cpu_data_in;

endmodule

// File: tb/tb_frost32_mem_bridge.sv
// ----------------------------------------------------------------------------
// tb_frost32_mem_bridge
//
// Directed vectors with hand-computed expectations for frost32_mem_bridge,
// built with TIMEOUT_CYCLES = 4. Inputs change just after a rising edge or
// on a falling edge; outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_frost32_mem_bridge;

  logic        clk;
  logic        rst_n;
  logic        cpu_req;
  logic        cpu_type;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_dout;
  logic [31:0] cpu_din;
  logic        cpu_wait;
  logic        cpu_err;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int n_vec;
  int n_miss;

  frost32_mem_bridge #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk                (clk),
    .i_rst_n              (rst_n),
    .i_cpu_req_mem_access (cpu_req),
    .i_cpu_access_type    (cpu_type),
    .i_cpu_access_size    (cpu_size),
    .i_cpu_addr           (cpu_addr),
    .i_cpu_data_out       (cpu_dout),
    .o_cpu_data_in        (cpu_din),
    .o_cpu_wait_for_mem   (cpu_wait),
    .o_cpu_bus_error      (cpu_err),
    .o_mem_req            (mem_req),
    .o_mem_we             (mem_we),
    .o_mem_addr           (mem_addr),
    .o_mem_byte_en        (mem_be),
    .o_mem_wdata          (mem_wdata),
    .i_mem_rdata          (mem_rdata),
    .i_mem_ack            (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // One CPU access. ack_dly = index of the ISSUE cycle that sees ack
  // (0 = first ISSUE cycle, -1 = never). Collects what the CPU and bus saw.
  task automatic do_access(
    input  string       name,
    input  logic        wr,
    input  logic [1:0]  sz,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    input  int          ack_dly,
    input  logic [31:0] rd,
    output int          waits,
    output int          reqs,
    output logic [31:0] m_addr,
    output logic [31:0] m_be,
    output logic [31:0] m_wdata,
    output logic [31:0] m_we,
    output logic [31:0] dout,
    output logic [31:0] err,
    output logic [31:0] err_after
  );
    bit done;
    @(posedge clk);
    #1;
    cpu_req  = 1'b1;
    cpu_type = wr;
    cpu_size = sz;
    cpu_addr = addr;
    cpu_dout = wd;
    mem_ack  = 1'b0;
    waits = 0; reqs = 0; done = 1'b0;
    m_addr = 0; m_be = 0; m_wdata = 0; m_we = 0;
    dout = 32'hFFFF_FFFF; err = 32'hFFFF_FFFF; err_after = 32'hFFFF_FFFF;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (mem_req) begin
        if (reqs == 0) begin
          m_addr  = {2'b00, mem_addr};
          m_be    = {28'h0, mem_be};
          m_wdata = mem_wdata;
          m_we    = {31'h0, mem_we};
        end
        mem_ack   = (reqs == ack_dly);
        // Junk data while not acknowledging so a stray capture is visible.
        mem_rdata = mem_ack ? rd : 32'h0BAD_0BAD;
        reqs++;
      end else begin
        mem_ack = 1'b0;
      end
      if (cpu_wait) begin
        waits++;
      end else begin
        done = 1'b1;
        dout = cpu_din;
        err  = {31'h0, cpu_err};
        cpu_req = 1'b0;
      end
    end
    if (!done) begin
      waits   = 99;
      cpu_req = 1'b0;
    end
    mem_ack = 1'b0;
    @(negedge clk);
    err_after = {31'h0, cpu_err};
    $display("%s: type=%0d size=%0d addr=0x%08h waits=%0d reqs=%0d be=0x%0h wdata=0x%08h data_in=0x%08h err=%0d",
             name, wr, sz, addr, waits, reqs, m_be, m_wdata, dout, err[0]);
  endtask

  int          w, r;
  logic [31:0] ma, mb, mw, mwe, d, e, ea;

  initial begin
    n_vec = 0;
    n_miss = 0;
    rst_n = 1'b0;
    cpu_req = 1'b0; cpu_type = 1'b0; cpu_size = 2'd0;
    cpu_addr = 32'h0; cpu_dout = 32'h0;
    mem_rdata = 32'h0; mem_ack = 1'b0;

    repeat (3) @(negedge clk);
    check_vec("rst_mem_req",  {31'h0, mem_req}, 32'h0);
    check_vec("rst_mem_we",   {31'h0, mem_we}, 32'h0);
    check_vec("rst_mem_addr", {2'b0, mem_addr}, 32'h0);
    check_vec("rst_mem_be",   {28'h0, mem_be}, 32'h0);
    check_vec("rst_mem_wdata", mem_wdata, 32'h0);
    check_vec("rst_data_in",  cpu_din, 32'h0);
    check_vec("rst_bus_err",  {31'h0, cpu_err}, 32'h0);
    check_vec("rst_wait",     {31'h0, cpu_wait}, 32'h0);
    rst_n = 1'b1;
    $display("reset released");

    // Aligned 32-bit read, immediate ack.
    do_access("rd32", 1'b0, 2'd0, 32'h100, 32'h0, 0, 32'hDEADBEEF,
              w, r, ma, mb, mw, mwe, d, e, ea);
    check_vec("rd32_waits", 32'(w), 32'd2);
    check_vec("rd32_reqs",  32'(r), 32'd1);
    check_vec("rd32_addr",  ma, 32'h40);
    check_vec("rd32_be",    mb, 32'hF);
    check_vec("rd32_we",    mwe, 32'h0);
    check_vec("rd32_data",  d, 32'hDEADBEEF);
    check_vec("rd32_err",   e, 32'h0);
    check_vec("rd32_err_after", ea, 32'h0);

    // 8-bit write to lane 3; read data must stay untouched.
    do_access("wr8", 1'b1, 2'd2, 32'h103, 32'h000000A5, 0, 32'h11111111,
              w, r, ma, mb, mw, mwe, d, e, ea);
    check_vec("wr8_waits", 32'(w), 32'd2);
    check_vec("wr8_be",    mb, 32'h8);
    check_vec("wr8_wdata", mw, 32'hA5A5A5A5);
    check_vec("wr8_we",    mwe, 32'h1);
    check_vec("wr8_addr",  ma, 32'h40);
    check_vec("wr8_data_hold", d, 32'hDEADBEEF);
    check_vec("wr8_err",   e, 32'h0);

    // 16-bit write to upper half.
    do_access("wr16", 1'b1, 2'd1, 32'h102, 32'hFFFF1234, 0, 32'h0,
              w, r, ma, mb, mw, mwe, d, e, ea);
    check_vec("wr16_be",    mb, 32'hC);
    check_vec("wr16_wdata", mw, 32'h12341234);

    // 16-bit read of upper half.
    do_access("rd16", 1'b0, 2'd1, 32'h102, 32'h0, 0, 32'h12345678,
              w, r, ma, mb, mw, mwe, d, e, ea);
    check_vec("rd16_be",   mb, 32'hC);
    check_vec("rd16_data", d, 32'h00001234);

    // 8-bit read of lane 1.
    do_access("rd8", 1'b0, 2'd2, 32'h101, 32'h0, 0, 32'h12345678,
              w, r, ma, mb, mw, mwe, d, e, ea);
    check_vec("rd8_be",   mb, 32'h2);
    check_vec("rd8_data", d, 32'h00000056);

    // Misaligned 32-bit read: no bus cycle, one wait cycle, error pulse.
    do_access("mis32", 1'b0, 2'd0, 32'h102, 32'h0, 0, 32'hFFFFFFFF,
              w, r, ma, mb, mw, mwe, d, e, ea);
    check_vec("mis32_reqs",  32'(r), 32'd0);
    check_vec("mis32_waits", 32'(w), 32'd1);
    check_vec("mis32_err",   e, 32'h1);
    check_vec("mis32_err_after", ea, 32'h0);
    check_vec("mis32_data_hold", d, 32'h00000056);

    // Illegal size.
    do_access("size3", 1'b0, 2'd3, 32'h100, 32'h0, 0, 32'hFFFFFFFF,
              w, r, ma, mb, mw, mwe, d, e, ea);
    check_vec("size3_reqs",  32'(r), 32'd0);
    check_vec("size3_waits", 32'(w), 32'd1);
    check_vec("size3_err",   e, 32'h1);

    // Timeout: 4 ISSUE cycles, then error with zero data.
    do_access("tmo", 1'b0, 2'd0, 32'h200, 32'h0, -1, 32'h0,
              w, r, ma, mb, mw, mwe, d, e, ea);
    check_vec("tmo_reqs",  32'(r), 32'd4);
    check_vec("tmo_waits", 32'(w), 32'd5);
    check_vec("tmo_err",   e, 32'h1);
    check_vec("tmo_data",  d, 32'h0);
    check_vec("tmo_err_after", ea, 32'h0);

    // Ack in the last allowed ISSUE cycle completes normally.
    do_access("late_ack", 1'b0, 2'd0, 32'h204, 32'h0, 3, 32'hCAFEF00D,
              w, r, ma, mb, mw, mwe, d, e, ea);
    check_vec("late_reqs",  32'(r), 32'd4);
    check_vec("late_waits", 32'(w), 32'd5);
    check_vec("late_err",   e, 32'h0);
    check_vec("late_data",  d, 32'hCAFEF00D);

    // Reset in the middle of ISSUE.
    @(posedge clk);
    #1;
    cpu_req = 1'b1; cpu_type = 1'b1; cpu_size = 2'd0;
    cpu_addr = 32'h300; cpu_dout = 32'h55AA55AA;
    @(negedge clk);
    @(negedge clk);
    check_vec("rstmid_pre_req", {31'h0, mem_req}, 32'h1);
    cpu_req = 1'b0;
    rst_n = 1'b0;
    #1;
    check_vec("rstmid_req",     {31'h0, mem_req}, 32'h0);
    check_vec("rstmid_we",      {31'h0, mem_we}, 32'h0);
    check_vec("rstmid_addr",    {2'b0, mem_addr}, 32'h0);
    check_vec("rstmid_be",      {28'h0, mem_be}, 32'h0);
    check_vec("rstmid_wdata",   mem_wdata, 32'h0);
    check_vec("rstmid_data_in", cpu_din, 32'h0);
    check_vec("rstmid_wait",    {31'h0, cpu_wait}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    check_vec("stray_ack_req",  {31'h0, mem_req}, 32'h0);
    check_vec("stray_ack_err",  {31'h0, cpu_err}, 32'h0);
    @(negedge clk);
    check_vec("stray_ack_data", cpu_din, 32'h0);
    mem_ack = 1'b0;
    $display("mid-ISSUE reset and stray ack applied");

    do_access("post_rst_rd8", 1'b0, 2'd2, 32'h103, 32'h0, 0, 32'hAB000000,
              w, r, ma, mb, mw, mwe, d, e, ea);
    check_vec("post_rst_waits", 32'(w), 32'd2);
    check_vec("post_rst_be",    mb, 32'h8);
    check_vec("post_rst_data",  d, 32'h000000AB);
    check_vec("post_rst_err",   e, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
